adsr_env: RTL and testbench
===========================

Name: adsr_env

Overview:
- Linear ADSR envelope generator for the synth voice path.
- Consumes the 1 ms enable pulse produced by the millisecond tick generator. Produces an unsigned amplitude word for the downstream amplitude multiplier.
- Stage times are expressed in milliseconds per 1-LSB envelope step, so no divider is required.

Parameters:
- ENV_W, 8, envelope width; full scale ENV_MAX = 2^ENV_W - 1.
- RATE_W, 16, width of the per-stage rate inputs, in ms per LSB step.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- ms_tick  in  1  one-clk-wide pulse every 1 ms from the tick generator.
- gate  in  1  note-on level, synchronous to clk.
- attack_rate  in  RATE_W  ms per +1 step in ATTACK; 0 means instant.
- decay_rate  in  RATE_W  ms per -1 step in DECAY; 0 means instant.
- sustain_lvl  in  ENV_W  sustain amplitude.
- release_rate  in  RATE_W  ms per -1 step in RELEASE; 0 means instant.
- env  out  ENV_W  current envelope amplitude (registered).
- env_step  out  1  one-cycle pulse on every edge where env changes.
- busy  out  1  high when state != IDLE (registered).

Behaviour:
- Reset (async, active-high): state=IDLE, env=0, env_step=0, busy=0, gate_q=0, tick counter=0.
- Edge detection: gate_q registers gate. rise = gate & ~gate_q; fall = ~gate & gate_q.
- Tick counter (RATE_W bits):
  - Clears on every state change.
  - Otherwise increments on ms_tick.
  - step = ms_tick & (cnt == rate-1), where rate is the current stage's rate. On step the counter clears.
  - When rate=0, step=1 on every clk, regardless of ms_tick.
- env and the state update on the same edge as step. env_step=1 on that edge only if env actually changed.
- IDLE: env held at 0. rise -> ATTACK.
- ATTACK:
  - step: env+1.
  - On the edge where env becomes ENV_MAX (or env already equals ENV_MAX) -> DECAY.
  - fall -> RELEASE, keeping the current env.
- DECAY:
  - env <= sustain_lvl -> SUSTAIN, with no step; this covers sustain_lvl = ENV_MAX.
  - Otherwise on step: env-1.
  - fall -> RELEASE.
- SUSTAIN:
  - env tracks sustain_lvl every cycle; a live change asserts env_step.
  - fall -> RELEASE.
- RELEASE:
  - step: env-1, saturating at 0.
  - env==0 -> IDLE.
  - rise -> ATTACK from the current env (legato, no reset to 0).
- Priority on a single edge: fall/rise transitions win over the step-driven transition. A step is never applied on the edge where gate changes.
- Arithmetic: env is unsigned and never wraps. Increment saturates at ENV_MAX; decrement saturates at 0.
- Rate inputs are sampled live; a change takes effect at the next compare. If a new rate is <= cnt, the counter runs to wrap (2^RATE_W) before stepping. This is acceptable; software changes rates only in IDLE.
- ms_tick is ignored in IDLE and SUSTAIN; the counter is held at 0 there.

Optional Feature:
- Macro: ADSR_EXP_RELEASE_EN.
- Defined: each RELEASE step subtracts max(1, env >> 3), giving an exponential-like tail. It saturates at 0 and still exits to IDLE at env==0.
- Undefined: RELEASE subtracts exactly 1 per step.
- ATTACK and DECAY are unaffected in both cases.

Test Plan:
- Reset: assert reset mid-ATTACK with env=77 -> env=0, busy=0, state IDLE immediately (async), with no ms_tick needed.
- Full cycle: attack=1, decay=1, sustain=128, release=1, gate high; 1 ms_tick per 10 clks:
  - env reaches 255 after 255 ticks.
  - env reaches 128 after a further 127 ticks, then SUSTAIN.
  - gate low -> env 0 after 128 ticks, then IDLE and busy=0.
- Rate scaling: attack=3 -> env increments exactly every 3rd ms_tick; env=10 after 30 ticks, with env_step pulsed 10 times.
- Instant stages: attack=0, decay=0, sustain=64 -> env=255 within 256 clks of rise, then 64 after a further 191 clks, with no ms_tick required.
- Early release / legato:
  - gate falls at env=40 in ATTACK -> RELEASE from 40.
  - gate rises at env=25 -> ATTACK from 25, continuing upward.
- ADSR_EXP_RELEASE_EN: release from 200 with release=1 -> 175, 154, 135, ... down to 0 in finite ticks; the undefined build takes 200 ticks.

Source files
------------

// File: rtl/adsr_env.sv
// Linear ADSR envelope generator, stepped by a 1 ms tick with per-stage ms-per-LSB rates.
// Optional ADSR_EXP_RELEASE_EN: release steps subtract max(1, env>>3) for an exponential-like tail.
module adsr_env #(
   parameter int ENV_W  = 8,
   parameter int RATE_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ms_tick,
   input  logic              gate,
   input  logic [RATE_W-1:0] attack_rate,
   input  logic [RATE_W-1:0] decay_rate,
   input  logic [ENV_W-1:0]  sustain_lvl,
   input  logic [RATE_W-1:0] release_rate,
   output logic [ENV_W-1:0]  env,
   output logic              env_step,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ATTACK,
      S_DECAY,
      S_SUSTAIN,
      S_RELEASE
   } state_t;

   localparam logic [ENV_W-1:0] ENV_MAX = '1;

   state_t              state_q, state_d;
   logic [ENV_W-1:0]    env_q, env_d;
   logic                env_step_q, env_step_d;
   logic                busy_q, busy_d;
   logic                gate_q;
   logic [RATE_W-1:0]   cnt_q, cnt_d;

   logic                rise, fall, step;
   logic [RATE_W-1:0]   rate, rate_m1;
   logic [ENV_W-1:0]    rel_dec, rel_next;

   always_comb begin
      rise = gate & ~gate_q;
      fall = ~gate & gate_q;

      unique case (state_q)
         S_ATTACK:  rate = attack_rate;
         S_DECAY:   rate = decay_rate;
         S_RELEASE: rate = release_rate;
         default:   rate = '0;
      endcase
      rate_m1 = rate - RATE_W'(1);
      // A zero rate means the stage advances every clock, tick or not.
      step    = (rate == '0) || (ms_tick && (cnt_q == rate_m1));

`ifdef ADSR_EXP_RELEASE_EN
      rel_dec = ((env_q >> 3) == '0) ? ENV_W'(1) : (env_q >> 3);
`else
      rel_dec = ENV_W'(1);
`endif
      rel_next = (env_q > rel_dec) ? (env_q - rel_dec) : '0;

      state_d = state_q;
      env_d   = env_q;
      // Gate edges take priority; no step is applied on the edge they fire.
      unique case (state_q)
         S_IDLE: begin
            env_d = '0;
            if (rise) state_d = S_ATTACK;
         end
         S_ATTACK: begin
            if (fall) begin
               state_d = S_RELEASE;
            end else if (env_q == ENV_MAX) begin
               state_d = S_DECAY;
            end else if (step) begin
               env_d = env_q + ENV_W'(1);
               if (env_d == ENV_MAX) state_d = S_DECAY;
            end
         end
         S_DECAY: begin
            if (fall) begin
               state_d = S_RELEASE;
            end else if (env_q <= sustain_lvl) begin
               state_d = S_SUSTAIN;
            end else if (step) begin
               env_d = env_q - ENV_W'(1);
            end
         end
         S_SUSTAIN: begin
            if (fall) state_d = S_RELEASE;
            else      env_d   = sustain_lvl;
         end
         S_RELEASE: begin
            if (rise) begin
               state_d = S_ATTACK;
            end else if (env_q == '0) begin
               state_d = S_IDLE;
            end else if (step) begin
               env_d = rel_next;
            end
         end
         default: begin
            state_d = S_IDLE;
            env_d   = '0;
         end
      endcase

      if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_SUSTAIN) || step)
         cnt_d = '0;
      else if (ms_tick)
         cnt_d = cnt_q + RATE_W'(1);
      else
         cnt_d = cnt_q;

      env_step_d = (env_d != env_q);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         env_q      <= '0;
         env_step_q <= 1'b0;
         busy_q     <= 1'b0;
         gate_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         env_q      <= env_d;
         env_step_q <= env_step_d;
         busy_q     <= busy_d;
         gate_q     <= gate;
         cnt_q      <= cnt_d;
      end
   end

   assign env      = env_q;
   assign env_step = env_step_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_adsr_env.sv
// Directed bench for adsr_env: stimulus queues expected env values, a monitor checks each env_step.
module tb_adsr_env;
   localparam int ENV_W  = 8;
   localparam int RATE_W = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              ms_tick = 1'b0;
   logic              gate = 1'b0;
   logic [RATE_W-1:0] attack_rate = 16'd1;
   logic [RATE_W-1:0] decay_rate = 16'd1;
   logic [ENV_W-1:0]  sustain_lvl = 8'd128;
   logic [RATE_W-1:0] release_rate = 16'd1;
   logic [ENV_W-1:0]  env;
   logic              env_step;
   logic              busy;

   int total = 0;
   int bad = 0;
   int nsteps = 0;
   int prev_env = 0;
   int exp_q[$];

   adsr_env #(.ENV_W(ENV_W), .RATE_W(RATE_W)) dut (
      .clk(clk), .reset(reset), .ms_tick(ms_tick), .gate(gate),
      .attack_rate(attack_rate), .decay_rate(decay_rate),
      .sustain_lvl(sustain_lvl), .release_rate(release_rate),
      .env(env), .env_step(env_step), .busy(busy)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   // Monitor: every env_step pops one expected value; env may only move with env_step.
   always @(negedge clk) begin
      if (reset) begin
         prev_env = 0;
      end else begin
         if (env_step) begin
            nsteps++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_step: got env=%0d, want no step", env);
            end else begin
               chk("env_seq", int'(env), exp_q.pop_front());
            end
         end
         if ((int'(env) != prev_env) != env_step) begin
            total++;
            bad++;
            $display("FAIL step_flag: got env_step=%0d (env %0d->%0d), want %0d",
                     env_step, prev_env, env, int'(env) != prev_env);
         end
         prev_env = int'(env);
      end
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         ms_tick = 1'b1;
         @(negedge clk);
         ms_tick = 1'b0;
         repeat (9) @(negedge clk);
      end
   endtask

   task automatic push_range(input int a, input int b);
      if (a <= b) for (int v = a; v <= b; v++) exp_q.push_back(v);
      else        for (int v = a; v >= b; v--) exp_q.push_back(v);
   endtask

   function automatic int rel_next(input int v);
      int d;
`ifdef ADSR_EXP_RELEASE_EN
      d = v >> 3;
      if (d == 0) d = 1;
`else
      d = 1;
`endif
      return (v > d) ? v - d : 0;
   endfunction

   task automatic rel_to(input int from, input int stop, output int n);
      int v;
      v = from;
      n = 0;
      while (v > stop) begin
         v = rel_next(v);
         exp_q.push_back(v);
         n++;
      end
   endtask

   task automatic drain(input string name);
      clks(3);
      chk(name, exp_q.size(), 0);
   endtask

   initial begin
      int n;
      int base;

      // Reset state
      clks(3);
      chk("rst_env", int'(env), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_step", int'(env_step), 0);
      reset = 1'b0;
      clks(2);

      // Async reset mid-attack at env=77
      attack_rate = 16'd1;
      gate = 1'b1;
      clks(2);
      push_range(1, 77);
      ticks(77);
      chk("attack_77", int'(env), 77);
      chk("attack_busy", int'(busy), 1);
      drain("drain_77");
      #3 reset = 1'b1;
      #1;
      chk("async_env", int'(env), 0);
      chk("async_busy", int'(busy), 0);
      gate = 1'b0;
      clks(2);
      reset = 1'b0;
      clks(3);
      chk("post_rst_busy", int'(busy), 0);

      // Full cycle, 1 ms per step everywhere, sustain 128
      attack_rate = 16'd1; decay_rate = 16'd1; release_rate = 16'd1; sustain_lvl = 8'd128;
      gate = 1'b1;
      clks(2);
      push_range(1, 255);
      ticks(255);
      chk("full_peak", int'(env), 255);
      push_range(254, 128);
      ticks(127);
      clks(2);
      chk("full_sustain", int'(env), 128);
      chk("full_busy", int'(busy), 1);
      sustain_lvl = 8'd130;
      exp_q.push_back(130);
      clks(3);
      chk("sustain_track", int'(env), 130);
      sustain_lvl = 8'd128;
      exp_q.push_back(128);
      clks(3);
      ticks(5);
      chk("sustain_hold", int'(env), 128);
      gate = 1'b0;
      clks(2);
      rel_to(128, 0, n);
      ticks(n);
      clks(2);
      chk("full_end_env", int'(env), 0);
      chk("full_end_busy", int'(busy), 0);
      drain("drain_full");

      // Rate scaling: one step per 3 ticks
      attack_rate = 16'd3;
      base = nsteps;
      gate = 1'b1;
      clks(2);
      push_range(1, 9);
      ticks(29);
      chk("rate3_29", int'(env), 9);
      exp_q.push_back(10);
      ticks(1);
      chk("rate3_30", int'(env), 10);
      chk("rate3_pulses", nsteps - base, 10);
      ticks(2);
      chk("rate3_32", int'(env), 10);
      gate = 1'b0;
      clks(2);
      rel_to(10, 0, n);
      ticks(n);
      clks(2);
      chk("rate3_idle", int'(busy), 0);
      drain("drain_rate3");

      // Instant stages, no ms_tick
      attack_rate = 16'd0; decay_rate = 16'd0; sustain_lvl = 8'd64; release_rate = 16'd0;
      gate = 1'b1;
      push_range(1, 255);
      push_range(254, 64);
      clks(256);
      chk("inst_peak", int'(env), 255);
      clks(191);
      chk("inst_sustain", int'(env), 64);
      clks(2);
      chk("inst_busy", int'(busy), 1);
      gate = 1'b0;
      rel_to(64, 0, n);
      clks(n + 4);
      chk("inst_end_env", int'(env), 0);
      chk("inst_end_busy", int'(busy), 0);
      drain("drain_inst");

      // Early release at 40, legato re-attack at 25
      attack_rate = 16'd1; decay_rate = 16'd1; sustain_lvl = 8'd128; release_rate = 16'd1;
      gate = 1'b1;
      clks(2);
      push_range(1, 40);
      ticks(40);
      chk("early_40", int'(env), 40);
      gate = 1'b0;
      clks(2);
      chk("early_keep", int'(env), 40);
      rel_to(40, 25, n);
      ticks(n);
      chk("legato_25", int'(env), 25);
      gate = 1'b1;
      clks(2);
      push_range(26, 30);
      ticks(5);
      chk("legato_30", int'(env), 30);
      gate = 1'b0;
      clks(2);
      rel_to(30, 0, n);
      ticks(n);
      clks(2);
      chk("legato_idle", int'(busy), 0);
      drain("drain_legato");

      // Release from 200
      attack_rate = 16'd0; decay_rate = 16'd0; sustain_lvl = 8'd200; release_rate = 16'd1;
      gate = 1'b1;
      push_range(1, 255);
      push_range(254, 200);
      clks(256 + 55 + 3);
      chk("rel200_start", int'(env), 200);
      gate = 1'b0;
      clks(2);
`ifdef ADSR_EXP_RELEASE_EN
      exp_q.push_back(175);
      exp_q.push_back(154);
      exp_q.push_back(135);
      ticks(3);
      chk("exp_135", int'(env), 135);
      rel_to(135, 0, n);
      ticks(n);
`else
      push_range(199, 0);
      ticks(199);
      chk("lin_199", int'(env), 1);
      ticks(1);
`endif
      clks(2);
      chk("rel200_env", int'(env), 0);
      chk("rel200_busy", int'(busy), 0);
      drain("drain_rel200");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
